// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Provides the debounce FSM state enum, the frame classification enum,
// geometry constants and a helper that classifies a full-frame key map.
package keypad_pkg;

   localparam int unsigned KP_ROWS = 4;
   localparam int unsigned KP_COLS = 4;
   localparam int unsigned KEY_W   = 4;
   localparam int unsigned MAP_W   = KP_ROWS * KP_COLS;
   localparam int unsigned ENTRY_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_DB,
      HELD,
      REL_DB
   } kp_state_e;

   typedef enum logic [1:0] {
      NONE,
      SINGLE,
      MULTI
   } frame_class_e;

   typedef struct packed {
      frame_class_e     cls;
      logic [KEY_W-1:0] key;
   } frame_info_t;

   // Count pressed keys in a frame map (bit 4*row+col); key is valid for SINGLE only.
   function automatic frame_info_t classify(input logic [MAP_W-1:0] map);
      frame_info_t info;
      int unsigned hits;
      info.cls = NONE;
      info.key = '0;
      hits     = 0;
      for (int unsigned i = 0; i < MAP_W; i++) begin
         if (map[i]) begin
            hits++;
            info.key = KEY_W'(i);
         end
      end
      if (hits == 1) begin
         info.cls = SINGLE;
      end else if (hits > 1) begin
         info.cls = MULTI;
      end
      return info;
   endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Column-step divider: counts 0..SCAN_DIV-1 and flags the last count.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   tick_c_o    - combinational, high for one cycle every SCAN_DIV cycles
module scan_tick_gen #(
   parameter int unsigned SCAN_DIV = 40000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick_c_o
);

   localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick_c_o = (cnt_q == CNT_W'(SCAN_DIV - 1));

   // Wrap to zero on the tick cycle.
   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (tick_c_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner with frame-based debounce and a
// 32-bit hex entry shift register.
// Ports:
//   clk, rst_n - clock, async active-low reset
//   row_in     - keypad rows, low = pressed in the driven column
//   clear      - one-cycle request to zero entry
//   col_out    - active-low one-hot column drive
//   key_valid  - one-cycle pulse per accepted key
//   key_code   - last accepted key (4*row+col)
//   entry      - accepted digits, newest in [3:0]
module keypad_scan
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 40000,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [KP_ROWS-1:0] row_in,
   input  logic               clear,
   output logic [KP_COLS-1:0] col_out,
   output logic               key_valid,
   output logic [KEY_W-1:0]   key_code,
   output logic [ENTRY_W-1:0] entry
);

   localparam int unsigned COL_W  = $clog2(KP_COLS);
   localparam int unsigned CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
   localparam bit          DB_ONE = (DEBOUNCE_SCANS == 1);

   logic                tick;
   logic [KP_ROWS-1:0]  row_s1_q, row_s2_q;
   logic [COL_W-1:0]    col_q, col_d;
   logic [KP_COLS-1:0]  col_out_q, col_out_d;
   logic [MAP_W-1:0]    frame_q, frame_d;
   logic [MAP_W-1:0]    sample_map, frame_full;
   logic                frame_end;
   frame_info_t         info;
   kp_state_e           state_q, state_d;
   logic [KEY_W-1:0]    cand_q, cand_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
   logic                accept;
   logic [KEY_W-1:0]    accept_code;
   logic                key_valid_q, key_valid_d;
   logic [KEY_W-1:0]    key_code_q, key_code_d;
   logic [ENTRY_W-1:0]  entry_q, entry_d;

   scan_tick_gen #(
      .SCAN_DIV (SCAN_DIV)
   ) u_tick (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick_c_o (tick)
   );

   // Row synchronizer; idles high to match the external pull-ups.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_s1_q <= '1;
         row_s2_q <= '1;
      end else begin
         row_s1_q <= row_in;
         row_s2_q <= row_s1_q;
      end
   end

   // Column scan and frame map; column 3 sample is folded in before classification.
   always_comb begin
      sample_map = '0;
      for (int r = 0; r < int'(KP_ROWS); r++) begin
         sample_map[r * int'(KP_COLS) + int'(col_q)] = ~row_s2_q[r];
      end
      frame_full = frame_q | sample_map;
      frame_end  = tick && (col_q == COL_W'(KP_COLS - 1));
      info       = classify(frame_full);

      frame_d    = frame_q;
      col_d      = col_q;
      if (tick) begin
         col_d   = col_q + COL_W'(1);
         frame_d = frame_end ? '0 : frame_full;
      end
      col_out_d  = ~(KP_COLS'(1) << col_d);
   end

   // Debounce FSM, advanced only at frame end.
   always_comb begin
      state_d     = state_q;
      cand_d      = cand_q;
      cnt_d       = cnt_q;
      accept      = 1'b0;
      accept_code = cand_q;
      cnt_inc     = cnt_q + CNT_W'(1);

      if (frame_end) begin
         case (state_q)
            IDLE: begin
               if (info.cls == SINGLE) begin
                  cand_d      = info.key;
                  cnt_d       = CNT_W'(1);
                  accept_code = info.key;
                  if (DB_ONE) begin
                     accept  = 1'b1;
                     state_d = HELD;
                  end else begin
                     state_d = PRESS_DB;
                  end
               end
            end
            PRESS_DB: begin
               if (info.cls == SINGLE) begin
                  if (info.key == cand_q) begin
                     cnt_d = cnt_inc;
                     if (cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
                        accept  = 1'b1;
                        state_d = HELD;
                     end
                  end else begin
                     cand_d = info.key;
                     cnt_d  = CNT_W'(1);
                  end
               end else begin
                  state_d = IDLE;
               end
            end
            HELD: begin
               if (info.cls == NONE) begin
                  cnt_d   = CNT_W'(1);
                  state_d = DB_ONE ? IDLE : REL_DB;
               end
            end
            REL_DB: begin
               if (info.cls == NONE) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
                     state_d = IDLE;
                  end
               end else begin
                  state_d = HELD;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Output staging; clear overrides the entry shift but not the key report.
   always_comb begin
      key_valid_d = accept;
      key_code_d  = key_code_q;
      entry_d     = entry_q;
      if (accept) begin
         key_code_d = accept_code;
         entry_d    = {entry_q[ENTRY_W-KEY_W-1:0], accept_code};
      end
      if (clear) begin
         entry_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q       <= '0;
         col_out_q   <= KP_COLS'(4'b1110);
         frame_q     <= '0;
         state_q     <= IDLE;
         cand_q      <= '0;
         cnt_q       <= '0;
         key_valid_q <= 1'b0;
         key_code_q  <= '0;
         entry_q     <= '0;
      end else begin
         col_q       <= col_d;
         col_out_q   <= col_out_d;
         frame_q     <= frame_d;
         state_q     <= state_d;
         cand_q      <= cand_d;
         cnt_q       <= cnt_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
         entry_q     <= entry_d;
      end
   end

   assign col_out   = col_out_q;
   assign key_valid = key_valid_q;
   assign key_code  = key_code_q;
   assign entry     = entry_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed self-checking bench for keypad_scan (SCAN_DIV=4, DEBOUNCE_SCANS=2).
// A behavioural keypad model drives row_in from a pressed-key mask and col_out.
module tb_keypad_scan;
   import keypad_pkg::*;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  row_in;
   logic        clear = 1'b0;
   logic [3:0]  col_out;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [31:0] entry;
   logic [15:0] pressed = '0;

   int   checks    = 0;
   int   failures  = 0;
   int   pulse_cnt = 0;
   int   dbl_cnt   = 0;
   logic prev_kv   = 1'b0;
   logic [3:0] last_code = '0;

   keypad_scan #(
      .SCAN_DIV       (4),
      .DEBOUNCE_SCANS (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .row_in    (row_in),
      .clear     (clear),
      .col_out   (col_out),
      .key_valid (key_valid),
      .key_code  (key_code),
      .entry     (entry)
   );

   always #5 clk = ~clk;

   // Row r is pulled low when any pressed key in row r sits in the driven column.
   always_comb begin
      for (int r = 0; r < 4; r++) begin
         row_in[r] = ~|(pressed[4*r +: 4] & ~col_out);
      end
   end

   always @(negedge clk) begin
      if (key_valid) begin
         pulse_cnt++;
         last_code = key_code;
         if (prev_kv) dbl_cnt++;
      end
      prev_kv = key_valid;
   end

   // Returns on the falling edge just after the n-th frame-end edge.
   task automatic wait_frames(input int n);
      int seen = 0;
      logic [3:0] last;
      last = col_out;
      for (int i = 0; i < n * 16 + 40 && seen < n; i++) begin
         @(negedge clk);
         if (col_out == 4'b1110 && last != 4'b1110) seen++;
         last = col_out;
      end
      if (seen < n) begin
         checks++; failures++;
         $display("FAIL wait_frames: saw %0d frame ends, required %0d", seen, n);
      end
   endtask

   task automatic press_release(input int k, input int hold, input int rel);
      pressed    = '0;
      pressed[k] = 1'b1;
      wait_frames(hold);
      pressed = '0;
      wait_frames(rel);
   endtask

   task automatic test_reset();
      #3 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (col_out !== 4'b1110) begin failures++; $display("FAIL reset_col_out: got %b want 1110", col_out); end
      checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_key_valid: got %b want 0", key_valid); end
      checks++; if (key_code !== 4'h0) begin failures++; $display("FAIL reset_key_code: got %h want 0", key_code); end
      checks++; if (entry !== 32'h0) begin failures++; $display("FAIL reset_entry: got %h want 0", entry); end
      rst_n = 1'b1;
   endtask

   task automatic test_single_hold();
      int p0 = pulse_cnt;
      press_release(6, 12, 3);
      checks++; if (pulse_cnt - p0 !== 1) begin failures++; $display("FAIL hold_pulses: got %0d want 1", pulse_cnt - p0); end
      checks++; if (key_code !== 4'h6) begin failures++; $display("FAIL hold_key_code: got %h want 6", key_code); end
      checks++; if (entry !== 32'h00000006) begin failures++; $display("FAIL hold_entry: got %h want 00000006", entry); end
   endtask

   task automatic test_digits();
      int p0 = pulse_cnt;
      for (int d = 1; d <= 9; d++) press_release(d, 3, 3);
      checks++; if (pulse_cnt - p0 !== 9) begin failures++; $display("FAIL digits_pulses: got %0d want 9", pulse_cnt - p0); end
      checks++; if (entry !== 32'h23456789) begin failures++; $display("FAIL digits_entry: got %h want 23456789", entry); end
      checks++; if (key_code !== 4'h9) begin failures++; $display("FAIL digits_key_code: got %h want 9", key_code); end
   endtask

   task automatic test_bounce();
      int p0 = pulse_cnt;
      pressed = 16'h0020;
      wait_frames(1);
      checks++; if (dut.state_q !== PRESS_DB) begin failures++; $display("FAIL bounce_state_pdb: got %0d want %0d", dut.state_q, PRESS_DB); end
      pressed = '0;
      wait_frames(1);
      pressed = 16'h0020;
      wait_frames(1);
      pressed = '0;
      wait_frames(3);
      checks++; if (pulse_cnt - p0 !== 0) begin failures++; $display("FAIL bounce_pulses: got %0d want 0", pulse_cnt - p0); end
      checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL bounce_state_idle: got %0d want %0d", dut.state_q, IDLE); end
   endtask

   task automatic test_multi();
      int p0 = pulse_cnt;
      pressed = 16'h0021;
      wait_frames(4);
      checks++; if (pulse_cnt - p0 !== 0) begin failures++; $display("FAIL multi_no_pulse: got %0d want 0", pulse_cnt - p0); end
      pressed = 16'h0020;
      wait_frames(2);
      pressed = '0;
      wait_frames(3);
      checks++; if (pulse_cnt - p0 !== 1) begin failures++; $display("FAIL multi_pulses: got %0d want 1", pulse_cnt - p0); end
      checks++; if (last_code !== 4'h5) begin failures++; $display("FAIL multi_pulse_code: got %h want 5", last_code); end
      checks++; if (key_code !== 4'h5) begin failures++; $display("FAIL multi_key_code: got %h want 5", key_code); end
   endtask

   task automatic test_clear_collision();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      checks++; if (entry !== 32'h0) begin failures++; $display("FAIL clear_entry: got %h want 0", entry); end
      press_release(10, 3, 3);
      press_release(11, 3, 3);
      checks++; if (entry !== 32'h000000AB) begin failures++; $display("FAIL clear_setup_entry: got %h want 000000AB", entry); end
      pressed = 16'h0008;
      wait_frames(1);
      repeat (15) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL collide_key_valid: got %b want 1", key_valid); end
      checks++; if (key_code !== 4'h3) begin failures++; $display("FAIL collide_key_code: got %h want 3", key_code); end
      checks++; if (entry !== 32'h0) begin failures++; $display("FAIL collide_entry: got %h want 0", entry); end
      wait_frames(1);
      pressed = '0;
      wait_frames(3);
      press_release(4, 3, 3);
      checks++; if (entry !== 32'h00000004) begin failures++; $display("FAIL after_clear_entry: got %h want 00000004", entry); end
   endtask

   task automatic test_reset_mid_frame();
      bit found = 1'b0;
      pressed = '0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (col_out == 4'b1011) found = 1'b1;
      end
      checks++; if (!found) begin failures++; $display("FAIL midrst_reach_col2: got %b want 1011", col_out); end
      rst_n = 1'b0;
      #1;
      checks++; if (col_out !== 4'b1110) begin failures++; $display("FAIL midrst_col_out: got %b want 1110", col_out); end
      checks++; if (entry !== 32'h0) begin failures++; $display("FAIL midrst_entry: got %h want 0", entry); end
      checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL midrst_key_valid: got %b want 0", key_valid); end
      checks++; if (key_code !== 4'h0) begin failures++; $display("FAIL midrst_key_code: got %h want 0", key_code); end
      @(negedge clk);
      rst_n = 1'b1;
      pressed = 16'h0010;
      repeat (3) @(negedge clk);
      checks++; if (col_out !== 4'b1110) begin failures++; $display("FAIL midrst_col0_hold: got %b want 1110", col_out); end
      @(negedge clk);
      checks++; if (col_out !== 4'b1101) begin failures++; $display("FAIL midrst_first_step: got %b want 1101", col_out); end
      wait_frames(2);
      pressed = '0;
      wait_frames(3);
      checks++; if (key_code !== 4'h4) begin failures++; $display("FAIL midrst_key_code_after: got %h want 4", key_code); end
      checks++; if (entry !== 32'h00000004) begin failures++; $display("FAIL midrst_entry_after: got %h want 00000004", entry); end
   endtask

   task automatic test_no_double_pulse();
      checks++; if (dbl_cnt !== 0) begin failures++; $display("FAIL double_pulse: got %0d want 0", dbl_cnt); end
   endtask

   initial begin
      test_reset();
      test_single_hold();
      test_digits();
      test_bounce();
      test_multi();
      test_clear_collision();
      test_reset_mid_frame();
      test_no_double_pulse();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
